// File: rtl/wired_inst_buffer_pkg.sv
// Shared definitions for the wired instruction buffer: default geometry
// and the classification of an offered fetch packet.
package wired_inst_buffer_pkg;

  localparam int FETCH_WIDTH_DEF = 2;
  localparam int ISSUE_WIDTH_DEF = 2;
  localparam int DEPTH_DEF       = 16;
  localparam int PAYLOAD_W_DEF   = 64;

  // What happens to the fetch packet offered this cycle.
  typedef enum logic [1:0] {
    ENQ_NONE  = 2'd0,  // nothing consumed (not offered, not ready, or flushed)
    ENQ_WRITE = 2'd1,  // current epoch, at least one live slot: written
    ENQ_STALE = 2'd2,  // wrong epoch: consumed and dropped
    ENQ_EMPTY = 2'd3   // all slots masked off: consumed, nothing written
  } enq_kind_e;

endpackage

// File: rtl/wired_inst_buffer_compact.sv
// Mask compactor: for every fetch slot, the number of live slots below it
// (its write offset from tail), plus the total live-slot count.
module wired_compact #(
  parameter int FETCH_WIDTH = 2,
  parameter int OFF_W       = $clog2(FETCH_WIDTH + 1)
) (
  input  logic [FETCH_WIDTH-1:0]       i_mask,
  output logic [FETCH_WIDTH*OFF_W-1:0] o_offset,
  output logic [OFF_W-1:0]             o_popcnt
);

  // Running prefix count over the mask, lowest slot first.
  always_comb begin
    logic [OFF_W-1:0] w_running;
    w_running = '0;
    o_offset  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      o_offset[i*OFF_W +: OFF_W] = w_running;
      w_running = w_running + OFF_W'(i_mask[i]);
    end
    o_popcnt = w_running;
  end

endmodule

// File: rtl/wired_inst_buffer.sv
// Instruction buffer between fetch and issue. Fetch packets with holes are
// compacted into a circular flop array; up to ISSUE_WIDTH oldest entries are
// presented each cycle straight from storage. A flush empties the buffer and
// installs a new epoch tag; packets from any other epoch are dropped.
module wired_inst_buffer
  import wired_inst_buffer_pkg::*;
#(
  parameter int FETCH_WIDTH = FETCH_WIDTH_DEF,
  parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int PAYLOAD_W   = PAYLOAD_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush_i,
  input  logic                             flush_tid_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [FETCH_WIDTH-1:0]           in_mask_i,
  input  logic                             in_tid_i,
  input  logic [FETCH_WIDTH*PAYLOAD_W-1:0] in_pkg_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [ISSUE_WIDTH-1:0]           out_mask_o,
  output logic [ISSUE_WIDTH*PAYLOAD_W-1:0] out_pkg_o,
  output logic [$clog2(DEPTH):0]           count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(FETCH_WIDTH + 1);

  logic [PAYLOAD_W-1:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]           r_head;
  logic [PTR_W-1:0]           r_tail;
  logic [CNT_W-1:0]           r_count;
  logic                       r_tid;

  logic [FETCH_WIDTH*OFF_W-1:0] w_offset;
  logic [OFF_W-1:0]             w_popcnt;
  logic [CNT_W-1:0]             w_free;
  logic                         w_accept;
  enq_kind_e                    w_kind;
  logic [CNT_W-1:0]             w_enq_n;
  logic [CNT_W-1:0]             w_deq_n;
  logic [PTR_W-1:0]             w_wr_idx [FETCH_WIDTH];

  wired_compact #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .OFF_W       (OFF_W)
  ) u_compact (
    .i_mask   (in_mask_i),
    .o_offset (w_offset),
    .o_popcnt (w_popcnt)
  );

  // Ready depends only on registered occupancy, so a full buffer never
  // relies on a same-cycle dequeue to make room.
  assign w_free     = CNT_W'(DEPTH) - r_count;
  assign in_ready_o = (w_free >= CNT_W'(FETCH_WIDTH));
  assign w_accept   = in_valid_i && in_ready_o && !flush_i;

  assign out_valid_o = (r_count != '0);
  assign count_o     = r_count;

  // Classify the offered packet: written, stale epoch, empty, or not taken.
  always_comb begin
    w_kind = ENQ_NONE;
    if (!w_accept) begin
      w_kind = ENQ_NONE;
    end else if (in_tid_i != r_tid) begin
      w_kind = ENQ_STALE;
    end else if (w_popcnt == '0) begin
      w_kind = ENQ_EMPTY;
    end else begin
      w_kind = ENQ_WRITE;
    end
  end

  // Number of entries added this cycle; only a written packet adds any.
  always_comb begin
    w_enq_n = '0;
    case (w_kind)
      ENQ_WRITE: w_enq_n = CNT_W'(w_popcnt);
      ENQ_STALE: w_enq_n = '0;
      ENQ_EMPTY: w_enq_n = '0;
      default:   w_enq_n = '0;
    endcase
  end

  // Number of entries retired this cycle: everything presented, if taken.
  always_comb begin
    w_deq_n = '0;
    if (out_valid_o && out_ready_i && !flush_i) begin
      if (r_count > CNT_W'(ISSUE_WIDTH)) begin
        w_deq_n = CNT_W'(ISSUE_WIDTH);
      end else begin
        w_deq_n = r_count;
      end
    end else begin
      w_deq_n = '0;
    end
  end

  // Thermometer mask and payloads of the oldest entries, read from storage.
  always_comb begin
    logic [PTR_W-1:0] w_rd_idx;
    out_mask_o = '0;
    out_pkg_o  = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      w_rd_idx      = r_head + PTR_W'(k);
      out_mask_o[k] = (r_count > CNT_W'(k));
      out_pkg_o[k*PAYLOAD_W +: PAYLOAD_W] = r_mem[w_rd_idx];
    end
  end

  // Target entry for each fetch slot: tail plus its compacted offset.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_wr_idx[i] = r_tail + PTR_W'(w_offset[i*OFF_W +: OFF_W]);
    end
  end

  // Pointer, occupancy and epoch state; flush overrides both handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_tid   <= 1'b0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_tid   <= flush_tid_i;
    end else begin
      r_tail  <= r_tail + PTR_W'(w_enq_n);
      r_head  <= r_head + PTR_W'(w_deq_n);
      r_count <= r_count + w_enq_n - w_deq_n;
    end
  end

  // Payload storage; contents carry no meaning outside [head, head+count).
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if ((w_kind == ENQ_WRITE) && in_mask_i[i]) begin
        r_mem[w_wr_idx[i]] <= in_pkg_i[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

endmodule

// File: tb/tb_wired_inst_buffer.sv
// Bench for wired_inst_buffer: directed scenarios with constant expectations,
// then a randomized run checked against a queue-based model.
module tb_wired_inst_buffer;

  logic         clk;
  logic         rst_n;
  logic         flush_i;
  logic         flush_tid_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [1:0]   in_mask_i;
  logic         in_tid_i;
  logic [127:0] in_pkg_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [1:0]   out_mask_o;
  logic [127:0] out_pkg_o;
  logic [4:0]   count_o;

  int checks;
  int errors;

  wired_inst_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .flush_tid_i (flush_tid_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_mask_i   (in_mask_i),
    .in_tid_i    (in_tid_i),
    .in_pkg_i    (in_pkg_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_mask_o  (out_mask_o),
    .out_pkg_o   (out_pkg_o),
    .count_o     (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] slot(input int k);
    return out_pkg_o[k*64 +: 64];
  endfunction

  task automatic set_idle();
    in_valid_i  = 1'b0;
    in_mask_i   = 2'b00;
    in_tid_i    = 1'b0;
    in_pkg_i    = '0;
    out_ready_i = 1'b0;
    flush_i     = 1'b0;
    flush_tid_i = 1'b0;
  endtask

  // Apply one cycle of stimulus, clock it in, return 1 ns after the edge.
  task automatic drive(input logic v, input logic [1:0] m, input logic t,
                       input logic [63:0] a0, input logic [63:0] a1,
                       input logic rdy, input logic fl, input logic ft);
    in_valid_i  = v;
    in_mask_i   = m;
    in_tid_i    = t;
    in_pkg_i    = {a1, a0};
    out_ready_i = rdy;
    flush_i     = fl;
    flush_tid_i = ft;
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    #12;
    checks += 4;
    if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
    if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready_o); end
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid_o); end
    if (out_mask_o !== 2'b00) begin errors++; $display("FAIL reset_out_mask got %b want 00", out_mask_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_push();
    drive(1'b1, 2'b10, 1'b0, 64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B, 1'b0, 1'b0, 1'b0);
    checks += 4;
    if (out_mask_o !== 2'b01) begin errors++; $display("FAIL single_mask got %b want 01", out_mask_o); end
    if (slot(0) !== 64'hBBBB_0000_0000_000B) begin errors++; $display("FAIL single_pkg0 got %h want BBBB00000000000B", slot(0)); end
    if (count_o !== 5'd1) begin errors++; $display("FAIL single_count got %0d want 1", count_o); end
    if (out_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid_o); end
    drive(1'b0, 2'b00, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (count_o !== 5'd0) begin errors++; $display("FAIL single_pop_count got %0d want 0", count_o); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (in_ready_o !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b want 1", i, in_ready_o); end
      drive(1'b1, 2'b11, 1'b0, 64'h100 + 64'(2*i), 64'h100 + 64'(2*i+1), 1'b0, 1'b0, 1'b0);
    end
    checks += 2;
    if (count_o !== 5'd16) begin errors++; $display("FAIL fill_count got %0d want 16", count_o); end
    if (in_ready_o !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b want 0", in_ready_o); end
    drive(1'b1, 2'b11, 1'b0, 64'hDEAD, 64'hBEEF, 1'b0, 1'b0, 1'b0);
    checks += 3;
    if (count_o !== 5'd16) begin errors++; $display("FAIL ninth_count got %0d want 16", count_o); end
    if (slot(0) !== 64'h100) begin errors++; $display("FAIL ninth_pkg0 got %h want 100", slot(0)); end
    if (slot(1) !== 64'h101) begin errors++; $display("FAIL ninth_pkg1 got %h want 101", slot(1)); end
    drive(1'b0, 2'b00, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (count_o !== 5'd0) begin errors++; $display("FAIL fill_flush_count got %0d want 0", count_o); end
  endtask

  task automatic test_flush_epoch();
    drive(1'b0, 2'b00, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 2'b11, 1'b0, 64'h51, 64'h52, 1'b0, 1'b0, 1'b0);
    checks += 2;
    if (count_o !== 5'd0) begin errors++; $display("FAIL stale_count got %0d want 0", count_o); end
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL stale_valid got %b want 0", out_valid_o); end
    drive(1'b1, 2'b11, 1'b1, 64'hC0, 64'hD0, 1'b0, 1'b0, 1'b0);
    checks += 4;
    if (count_o !== 5'd2) begin errors++; $display("FAIL epoch_count got %0d want 2", count_o); end
    if (out_mask_o !== 2'b11) begin errors++; $display("FAIL epoch_mask got %b want 11", out_mask_o); end
    if (slot(0) !== 64'hC0) begin errors++; $display("FAIL epoch_pkg0 got %h want c0", slot(0)); end
    if (slot(1) !== 64'hD0) begin errors++; $display("FAIL epoch_pkg1 got %h want d0", slot(1)); end
  endtask

  task automatic test_wrap();
    drive(1'b0, 2'b00, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b1, 2'b11, 1'b0, 64'(i), 64'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 2'b00, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 1'b0, 64'hE14, 64'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 1'b0, 64'hE15, 64'd0, 1'b0, 1'b0, 1'b0);
    checks += 2;
    if (count_o !== 5'd1) begin errors++; $display("FAIL wrap_pre_count got %0d want 1", count_o); end
    if (slot(0) !== 64'hE15) begin errors++; $display("FAIL wrap_pre_pkg0 got %h want e15", slot(0)); end
    drive(1'b1, 2'b11, 1'b0, 64'hE00, 64'hE01, 1'b1, 1'b0, 1'b0);
    checks += 3;
    if (count_o !== 5'd2) begin errors++; $display("FAIL wrap_count got %0d want 2", count_o); end
    if (slot(0) !== 64'hE00) begin errors++; $display("FAIL wrap_pkg0 got %h want e00", slot(0)); end
    if (slot(1) !== 64'hE01) begin errors++; $display("FAIL wrap_pkg1 got %h want e01", slot(1)); end
    drive(1'b0, 2'b00, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b11, 1'b0, 64'hF0, 64'hF1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 1'b0, 64'hF2, 64'hF3, 1'b1, 1'b0, 1'b0);
    checks += 3;
    if (count_o !== 5'd2) begin errors++; $display("FAIL b2b_count got %0d want 2", count_o); end
    if (slot(0) !== 64'hF2) begin errors++; $display("FAIL b2b_pkg0 got %h want f2", slot(0)); end
    if (slot(1) !== 64'hF3) begin errors++; $display("FAIL b2b_pkg1 got %h want f3", slot(1)); end
    drive(1'b1, 2'b11, 1'b0, 64'hF4, 64'hF5, 1'b1, 1'b1, 1'b0);
    checks += 3;
    if (count_o !== 5'd0) begin errors++; $display("FAIL flushin_count got %0d want 0", count_o); end
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flushin_valid got %b want 0", out_valid_o); end
    if (out_mask_o !== 2'b00) begin errors++; $display("FAIL flushin_mask got %b want 00", out_mask_o); end
    drive(1'b1, 2'b01, 1'b0, 64'hF6, 64'd0, 1'b0, 1'b0, 1'b0);
    checks += 2;
    if (count_o !== 5'd1) begin errors++; $display("FAIL post_flush_count got %0d want 1", count_o); end
    if (slot(0) !== 64'hF6) begin errors++; $display("FAIL post_flush_pkg0 got %h want f6", slot(0)); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 2'b11, 1'b0, 64'h1, 64'h2, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 1'b0, 64'h3, 64'h4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (count_o !== 5'd0) begin errors++; $display("FAIL async_count got %0d want 0", count_o); end
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL async_valid got %b want 0", out_valid_o); end
    if (out_mask_o !== 2'b00) begin errors++; $display("FAIL async_mask got %b want 00", out_mask_o); end
    if (in_ready_o !== 1'b1) begin errors++; $display("FAIL async_ready got %b want 1", in_ready_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Randomized traffic against an in-order queue model of the buffer.
  task automatic test_random();
    logic [63:0] q[$];
    logic        mtid;
    int          sz;
    int          deq;
    logic        v, t, rdy, fl, ft;
    logic [1:0]  m;
    logic [63:0] a0, a1;
    logic [1:0]  exp_mask;
    mtid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      v   = ($urandom_range(0, 9) < 7);
      m   = 2'($urandom_range(0, 3));
      t   = ($urandom_range(0, 4) == 0) ? ~mtid : mtid;
      rdy = ($urandom_range(0, 1) == 1);
      fl  = ($urandom_range(0, 19) == 0);
      ft  = 1'($urandom_range(0, 1));
      a0  = {$urandom, $urandom};
      a1  = {$urandom, $urandom};
      sz  = q.size();
      if (fl) begin
        q.delete();
        mtid = ft;
      end else begin
        deq = (rdy && sz > 0) ? ((sz > 2) ? 2 : sz) : 0;
        for (int d = 0; d < deq; d++) void'(q.pop_front());
        if (v && (16 - sz) >= 2 && t == mtid) begin
          if (m[0]) q.push_back(a0);
          if (m[1]) q.push_back(a1);
        end
      end
      drive(v, m, t, a0, a1, rdy, fl, ft);
      sz = q.size();
      exp_mask = (sz >= 2) ? 2'b11 : ((sz == 1) ? 2'b01 : 2'b00);
      checks += 4;
      if (count_o !== 5'(sz)) begin errors++; $display("FAIL rand_count cyc %0d got %0d want %0d", c, count_o, sz); end
      if (in_ready_o !== ((16 - sz) >= 2)) begin errors++; $display("FAIL rand_ready cyc %0d got %b want %b", c, in_ready_o, ((16 - sz) >= 2)); end
      if (out_valid_o !== (sz != 0)) begin errors++; $display("FAIL rand_valid cyc %0d got %b want %b", c, out_valid_o, (sz != 0)); end
      if (out_mask_o !== exp_mask) begin errors++; $display("FAIL rand_mask cyc %0d got %b want %b", c, out_mask_o, exp_mask); end
      for (int k = 0; k < 2; k++) begin
        if (k < sz) begin
          checks++;
          if (slot(k) !== q[k]) begin errors++; $display("FAIL rand_pkg%0d cyc %0d got %h want %h", k, c, slot(k), q[k]); end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_idle();
    test_reset();
    test_single_push();
    test_fill();
    test_flush_epoch();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wired_inst_buffer.md
WIRED_INST_BUFFER -- requirements
Module: wired_inst_buffer

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 2, meaning the number of instruction slots per fetch packet on the input side.
REQ-002 SHALL have parameter ISSUE_WIDTH, default 2, meaning the maximum number of instructions presented per cycle on the output side.
REQ-003 SHALL have parameter DEPTH, default 16, meaning entry count; it is a power of two and at least FETCH_WIDTH + ISSUE_WIDTH.
REQ-004 SHALL have parameter PAYLOAD_W, default 64, meaning the bit width of one instruction slot payload.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port flush_i, input, 1 bit: redirect or flush request.
REQ-008 SHALL have port flush_tid_i, input, 1 bit: new thread/epoch tag, taken when flush_i is high.
REQ-009 SHALL have port in_valid_i, input, 1 bit: a fetch packet is offered.
REQ-010 SHALL have port in_ready_o, output, 1 bit: the buffer can accept a packet.
REQ-011 SHALL have port in_mask_i, input, FETCH_WIDTH bits: per-slot valid mask; holes are allowed.
REQ-012 SHALL have port in_tid_i, input, 1 bit: epoch tag of the offered packet.
REQ-013 SHALL have port in_pkg_i, input, FETCH_WIDTH x PAYLOAD_W bits: slot payloads.
REQ-014 SHALL have port out_valid_o, output, 1 bit: at least one instruction is presented.
REQ-015 SHALL have port out_ready_i, input, 1 bit: the consumer takes everything presented this cycle.
REQ-016 SHALL have port out_mask_o, output, ISSUE_WIDTH bits: thermometer mask of the presented slots.
REQ-017 SHALL have port out_pkg_o, output, ISSUE_WIDTH x PAYLOAD_W bits: presented payloads, oldest in slot 0.
REQ-018 SHALL have port count_o, output, clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-019 SHALL keep head and tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register of clog2(DEPTH)+1 bits.
REQ-020 SHALL drive in_ready_o = (DEPTH - count) >= FETCH_WIDTH, computed from registered count only, independent of same-cycle dequeue.
REQ-021 SHALL accept a packet when in_valid_i && in_ready_o && !flush_i.
REQ-022 SHALL, on acceptance with in_tid_i == cur_tid, write the masked slots compacted in ascending slot index to tail, tail+1, ..., and advance tail by popcount(in_mask_i).
REQ-023 SHALL, on acceptance with in_tid_i != cur_tid, consume and discard the packet (stale epoch) with no pointer change.
REQ-024 SHALL consume a packet with all-zero mask without writing and without advancing tail.
REQ-025 SHALL drive out_mask_o with the low min(count, ISSUE_WIDTH) bits set and out_valid_o = (count != 0); out_pkg_o[k] SHALL be entry head+k mod DEPTH, with slots outside the mask don't-care.
REQ-026 SHALL, when out_valid_o && out_ready_i && !flush_i, advance head by popcount(out_mask_o).
REQ-027 SHALL hold the read path combinational from storage: an entry written in cycle N SHALL be presentable in cycle N+1 (latency 1); no bypass of same-cycle input.
REQ-028 SHALL, on simultaneous enqueue and dequeue, update count = count + enq_n - deq_n in one cycle; count SHALL never exceed DEPTH nor underflow.
REQ-029 SHALL, when flush_i is high, set head = tail = count = 0 and cur_tid = flush_tid_i next cycle; same-cycle input and output handshakes SHALL have no effect.
REQ-030 SHALL keep out_pkg_o stable while out_valid_o && !out_ready_i && !flush_i, even if enqueues occur.

Reset
REQ-031 SHALL, while rst_n is low, asynchronously force head=0, tail=0, count=0, cur_tid=0; hence out_valid_o=0, out_mask_o=0, count_o=0, in_ready_o=1.
REQ-032 SHALL leave payload storage unreset; reset mid-operation discards all contents.

Structure
REQ-033 SHALL place any shared packet struct (slot payload, mask, tid) in the common wired package; module-local parameters stay local.
REQ-034 SHALL use one sub-module, wired_compact, as a combinational FETCH_WIDTH-input mask compactor that produces per-slot write offsets and popcount.
REQ-035 SHALL implement storage as a flop array of DEPTH x PAYLOAD_W.

Verification
REQ-036 Defaults, reset, then push mask=2'b10 tid=0 payload {B,A} -> next cycle out_mask=2'b01, out_pkg[0]=B, count=1.
REQ-037 Push 8 packets mask=2'b11 with out_ready_i=0 -> count=16, in_ready_o=0 while count>14; ninth packet not accepted.
REQ-038 Flush with flush_tid_i=1, then push tid=0 mask=2'b11 -> discarded, count stays 0; then push tid=1 -> count=2.
REQ-039 Head at 15, push mask=2'b11 with out_ready_i=1 and count=1 -> wraps to entries 15,0,1, count=2, in-order output.
REQ-040 Push and pop in the same cycle, and assert flush_i together with in_valid_i -> count=0 next cycle and nothing written.
REQ-041 Drop rst_n asynchronously mid-burst -> outputs return to reset values before the next clk edge.
